bpd_update_dispatch: RTL
========================

# bpd_update_dispatch

Consumer-side endpoint for the branch-predictor update stream. Accepts one arbitrated update per cycle into a small FIFO and broadcasts each head entry to `N_BANKS` predictor banks. Each bank handshakes independently (eager fork). An entry retires only after every bank that needs it has accepted it. It sits between the update arbiter's single output and the per-component predictor update ports.

## Interface
Parameters:
- `N_BANKS`, default 4: number of predictor banks fed.
- `DEPTH`, default 2: FIFO entries; must be a power of 2 and ≥ 2.
- `REPAIR_MASK`, default 4'b0011: bit i set means bank i also receives repair updates.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `io_in_valid` / `io_in_ready`  in/out  1/1  upstream handshake.
- `io_in_bits_is_mispredict_update`, `io_in_bits_is_repair_update`  in  1 each.
- `io_in_bits_pc`  in  40.
- `io_in_bits_br_mask`  in  4.
- `io_in_bits_cfi_idx_valid`  in  1.
- `io_in_bits_cfi_idx_bits`  in  2.
- `io_in_bits_cfi_taken`  in  1.
- `io_in_bits_cfi_mispredicted`  in  1.
- `io_in_bits_target`  in  40.
- `io_in_bits_meta_0`  in  45.
- `io_in_source`  in  1: arbiter chosen index, stored with the entry.
- `io_flush`  in  1: discard all buffered updates.
- `io_out_valid`  out  N_BANKS: per-bank valid.
- `io_out_ready`  in  N_BANKS: per-bank ready.
- `io_out_bits_*`  out: same fields and widths as `io_in_bits_*`, broadcast from the head entry.
- `io_out_source`  out  1.
- `io_busy`  out  1: FIFO non-empty.

## Operation
- **Storage:** FIFO of `DEPTH` entries (payload plus source), with `head` and `tail` pointers of log2(DEPTH) bits that wrap modulo DEPTH, and a `count` of log2(DEPTH)+1 bits.
- **Enqueue:** `io_in_ready` = `count != DEPTH && !io_flush`. Enqueue occurs when `io_in_valid && io_in_ready`. There is no bypass and `io_in_ready` never depends on `io_out_ready`.
- **Per-bank need vector:** `need` = head `is_repair_update` ? `REPAIR_MASK` : all ones.
- **Delivered mask:** register `sent[N_BANKS]`.
- **Per-bank valid:** `io_out_valid[i]` = `count != 0 && need[i] && !sent[i]`.
- **Per-bank fire:** `fire[i]` = `io_out_valid[i] && io_out_ready[i]`.
- **Retire:** `done` = `sent | fire | ~need`. When `count != 0` and `done` is all ones:
  - head advances;
  - `sent` is cleared to 0.
- **Partial acceptance:** otherwise `sent <= sent | fire`.
- **Payload stability:** `io_out_bits_*` hold the head entry and stay stable until retire.
- **Simultaneous enqueue and retire:** `count` is unchanged; both pointers advance.
- **Flush:** `io_flush` has highest priority. Next cycle `count`, `head`, `tail` and `sent` are 0. Any fire in the flush cycle is still delivered to that bank; the entry is dropped anyway. Enqueue is blocked in the flush cycle.
- **Zero-need entry:** a repair entry with `REPAIR_MASK`=0 has `need`=0. It retires in the cycle it reaches the head and asserts no `io_out_valid`.
- **Idle bits:** with `count == 0`, `io_out_bits_*` are don't-care and all `io_out_valid` are 0.

## Timing
- **Reset values:** `count`=0, `head`=0, `tail`=0, `sent`=0. Hence `io_out_valid`=0, `io_busy`=0, `io_in_ready`=1 (absent flush), and `io_out_bits_*`/`io_out_source`=0 (storage reset to 0).
- **Latency:** an entry enqueued in cycle t is visible at `io_out_*` in cycle t+1 when the FIFO was empty.
- **Throughput:** with all banks ready, one update retires per cycle sustained.
- **Handshake rule:** a bank that has fired sees its `io_out_valid` low until the next head entry. Each bank accepts each entry exactly once.
- **Mid-operation reset:** reset asserted asynchronously clears all state immediately; outputs take their reset values within the same cycle.

## Structure
- A shared package holds:
  - the `bpd_update_t` packed struct for the payload fields;
  - `BPD_PC_W`=40, `BPD_META_W`=45, `BPD_FETCH_W`=4.
- One sub-module, `bpd_update_fifo`: a generic DEPTH×width FIFO exposing `enq`/`deq`/`flush`/`count`.
- The top level holds the `sent` mask, the `need` logic and the retire logic.

## Test plan
- **Single update, all ready:** reset, then one non-repair update with pc=0x80001000 and all `io_out_ready`=1 → cycle t+1: `io_out_valid`=4'b1111 and `io_out_bits_pc`=0x80001000; cycle t+2: `io_busy`=0.
- **Staggered acceptance:** banks ready in order 0,1,2,3, one per cycle → each bank's valid drops after its fire; retire occurs in the fourth cycle; no bank sees the entry twice.
- **Repair routing:** a repair update with `REPAIR_MASK`=4'b0011 → `io_out_valid`=4'b0011; retires once banks 0 and 1 fire; banks 2 and 3 never go valid.
- **Backpressure, full:** all `io_out_ready`=0, three back-to-back inputs → `io_in_ready`=0 after two enqueues and the third waits. Releasing ready drains the updates in order (pc A, then B, then C) at one per cycle.
- **Flush:** flush asserted with FIFO full and `sent`=4'b0101 → next cycle `io_busy`=0 and all valids 0; a new update enqueued afterward reaches every bank with `sent` cleared.
- **Reset mid-stream:** reset asserted with `count`=2 → `io_out_valid`=0 immediately; after release, `io_in_ready`=1 and `count`=0.

Source files
------------

// File: rtl/bpd_update_dispatch_pkg.sv
// Shared types and widths for the branch-predictor update dispatch path.
package bpd_update_dispatch_pkg;

  localparam int BPD_PC_W    = 40;
  localparam int BPD_META_W  = 45;
  localparam int BPD_FETCH_W = 4;

  typedef struct packed {
    logic                           is_mispredict_update;
    logic                           is_repair_update;
    logic [BPD_PC_W-1:0]            pc;
    logic [BPD_FETCH_W-1:0]         br_mask;
    logic                           cfi_idx_valid;
    logic [$clog2(BPD_FETCH_W)-1:0] cfi_idx_bits;
    logic                           cfi_taken;
    logic                           cfi_mispredicted;
    logic [BPD_PC_W-1:0]            target;
    logic [BPD_META_W-1:0]          meta_0;
  } bpd_update_t;

  localparam int BPD_UPDATE_W = $bits(bpd_update_t);

endpackage

// File: rtl/bpd_update_fifo.sv
// Generic DEPTH x WIDTH FIFO with flush; storage is reset so idle outputs read as zero.
module bpd_update_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  input  logic             flush,
  output logic [WIDTH-1:0] deq_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;

  assign deq_data = mem[head];

  // DEPTH is a power of two, so pointer increment wraps naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        mem[tail] <= enq_data;
        tail      <= tail + AW'(1);
      end
      if (deq) head <= head + AW'(1);
      unique case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bpd_update_dispatch.sv
// Buffers arbitrated predictor updates and eagerly forks each head entry to all banks that need it.
module bpd_update_dispatch
  import bpd_update_dispatch_pkg::*;
#(
  parameter int                 N_BANKS     = 4,
  parameter int                 DEPTH       = 2,
  parameter logic [N_BANKS-1:0] REPAIR_MASK = 4'b0011
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_in_valid,
  output logic                     io_in_ready,
  input  logic                     io_in_bits_is_mispredict_update,
  input  logic                     io_in_bits_is_repair_update,
  input  logic [BPD_PC_W-1:0]      io_in_bits_pc,
  input  logic [BPD_FETCH_W-1:0]   io_in_bits_br_mask,
  input  logic                     io_in_bits_cfi_idx_valid,
  input  logic [1:0]               io_in_bits_cfi_idx_bits,
  input  logic                     io_in_bits_cfi_taken,
  input  logic                     io_in_bits_cfi_mispredicted,
  input  logic [BPD_PC_W-1:0]      io_in_bits_target,
  input  logic [BPD_META_W-1:0]    io_in_bits_meta_0,
  input  logic                     io_in_source,
  input  logic                     io_flush,
  output logic [N_BANKS-1:0]       io_out_valid,
  input  logic [N_BANKS-1:0]       io_out_ready,
  output logic                     io_out_bits_is_mispredict_update,
  output logic                     io_out_bits_is_repair_update,
  output logic [BPD_PC_W-1:0]      io_out_bits_pc,
  output logic [BPD_FETCH_W-1:0]   io_out_bits_br_mask,
  output logic                     io_out_bits_cfi_idx_valid,
  output logic [1:0]               io_out_bits_cfi_idx_bits,
  output logic                     io_out_bits_cfi_taken,
  output logic                     io_out_bits_cfi_mispredicted,
  output logic [BPD_PC_W-1:0]      io_out_bits_target,
  output logic [BPD_META_W-1:0]    io_out_bits_meta_0,
  output logic                     io_out_source,
  output logic                     io_busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  bpd_update_t           in_upd;
  bpd_update_t           head;
  logic [BPD_UPDATE_W:0] head_raw;
  logic [CW-1:0]         count;
  logic                  not_empty;
  logic                  enq;
  logic                  retire;
  logic [N_BANKS-1:0]    need;
  logic [N_BANKS-1:0]    sent;
  logic [N_BANKS-1:0]    fire;
  logic [N_BANKS-1:0]    done;

  assign in_upd = '{
    is_mispredict_update: io_in_bits_is_mispredict_update,
    is_repair_update:     io_in_bits_is_repair_update,
    pc:                   io_in_bits_pc,
    br_mask:              io_in_bits_br_mask,
    cfi_idx_valid:        io_in_bits_cfi_idx_valid,
    cfi_idx_bits:         io_in_bits_cfi_idx_bits,
    cfi_taken:            io_in_bits_cfi_taken,
    cfi_mispredicted:     io_in_bits_cfi_mispredicted,
    target:               io_in_bits_target,
    meta_0:               io_in_bits_meta_0
  };

  assign not_empty   = (count != '0);
  assign io_in_ready = (count != CW'(DEPTH)) && !io_flush;
  assign enq         = io_in_valid && io_in_ready;
  assign io_busy     = not_empty;

  bpd_update_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BPD_UPDATE_W + 1)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .enq      (enq),
    .enq_data ({io_in_source, in_upd}),
    .deq      (retire),
    .flush    (io_flush),
    .deq_data (head_raw),
    .count    (count)
  );

  assign head          = head_raw[BPD_UPDATE_W-1:0];
  assign io_out_source = head_raw[BPD_UPDATE_W];

  assign io_out_bits_is_mispredict_update = head.is_mispredict_update;
  assign io_out_bits_is_repair_update     = head.is_repair_update;
  assign io_out_bits_pc                   = head.pc;
  assign io_out_bits_br_mask              = head.br_mask;
  assign io_out_bits_cfi_idx_valid        = head.cfi_idx_valid;
  assign io_out_bits_cfi_idx_bits         = head.cfi_idx_bits;
  assign io_out_bits_cfi_taken            = head.cfi_taken;
  assign io_out_bits_cfi_mispredicted     = head.cfi_mispredicted;
  assign io_out_bits_target               = head.target;
  assign io_out_bits_meta_0               = head.meta_0;

  // Banks outside the repair mask never see repair updates; a zero need retires at once.
  assign need         = head.is_repair_update ? REPAIR_MASK : '1;
  assign io_out_valid = not_empty ? (need & ~sent) : '0;
  assign fire         = io_out_valid & io_out_ready;
  assign done         = sent | fire | ~need;
  assign retire       = not_empty && (&done);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sent <= '0;
    end else if (io_flush || retire) begin
      sent <= '0;
    end else begin
      sent <= sent | fire;
    end
  end

endmodule
